// File: rtl/seven_segment_n.sv
// N-digit multiplexed seven-segment driver with PWM brightness,
// per-digit blink/blank and leading-zero suppression.
module seven_segment_n #(
  parameter int NUM_DIGITS    = 8,
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int REFRESH_RATE  = 200,
  parameter int BLINK_RATE    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int SEGMENT_CLOCKS =
    CLK_FREQUENCY / (REFRESH_RATE * NUM_DIGITS);
  localparam int BLINK_HALF = CLK_FREQUENCY / (2 * BLINK_RATE);
  localparam int SW = $clog2(SEGMENT_CLOCKS + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int DW = $clog2(NUM_DIGITS);

  if (SEGMENT_CLOCKS < 16) begin : g_slot_chk
    $error("SEGMENT_CLOCKS must be at least 16");
  end
  if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_dig_chk
    $error("NUM_DIGITS must be 2..16");
  end

  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  logic          slot_end;
  logic          blink_end;
  logic [SW+4:0] prod;
  logic [SW:0]   on_clocks;
  logic          nz_above;
  logic          suppressed;
  logic          lit;
  logic [3:0]    nibble;
  logic [NUM_DIGITS-1:0] anode_d;
  logic [7:0]            segment_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end  = slot_cnt == SW'(SEGMENT_CLOCKS - 1);
  assign blink_end = blink_cnt == BW'(BLINK_HALF - 1);

  // Widened product so brightness 15 yields exactly SEGMENT_CLOCKS
  assign prod = (SW+5)'({1'b0, brightness} + 5'd1)
              * (SW+5)'(SEGMENT_CLOCKS);
  assign on_clocks = prod[SW+4:4];
  assign nibble    = data_in[4*digit_idx +: 4];

  always_comb begin
    nz_above = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(digit_idx) && data_in[4*j +: 4] != 4'd0)
        nz_above = 1'b1;
    end
  end

  assign suppressed = lz_suppress && digit_idx != '0 && !nz_above;

  always_comb begin
    lit = ({1'b0, slot_cnt} < on_clocks)
       && !blank[digit_idx]
       && !(blink[digit_idx] && !blink_on)
       && !suppressed;
    anode_d   = '1;
    segment_d = 8'hFF;
    if (lit) begin
      anode_d   = ~(NUM_DIGITS'(1) << digit_idx);
      segment_d = {~dp_in[digit_idx], hex7(nibble)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      anode     <= '1;
      segment   <= 8'hFF;
    end else begin
      anode   <= anode_d;
      segment <= segment_d;
      if (slot_end) begin
        slot_cnt <= '0;
        if (digit_idx == DW'(NUM_DIGITS - 1))
          digit_idx <= '0;
        else
          digit_idx <= digit_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (blink_end) begin
        blink_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule
